// File: rtl/calsoc_wb_pkg.sv
// calsoc_wb_pkg: shared Wishbone types and default widths for the CalSoC bus
// fabric.
//   arb_state_t  : arbiter state (IDLE, GRANT0, GRANT1, ABORT)
//   master_idx_t : index of one of the two arbitrated masters
//   WB_AW, WB_DW : default address / data widths
package calsoc_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_t;

    typedef logic master_idx_t;

    function automatic arb_state_t grant_state(input master_idx_t idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: transfer watchdog for wb_arbiter2.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   enable  : count this cycle (transfer outstanding, no response)
//   clear   : return the count to zero (has priority over enable)
//   expire  : combinational, high in the cycle the count sits at
//             TIMEOUT_CYCLES-1 while still enabled
// TIMEOUT_CYCLES = 0 removes the counter; expire is then constant 0.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = ^{clk, rst_n, enable, clear};
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

        logic [TW-1:0] count_q;

        assign expire = enable && !clear && (count_q == TW'(TIMEOUT_CYCLES - 1));

        // Holds at the limit; the arbiter leaves GRANTn on expire, which clears it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (clear) begin
                count_q <= '0;
            end else if (enable && !expire) begin
                count_q <= count_q + TW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master pipelined Wishbone arbiter in front of the crossbar.
// Grants per CYC envelope with round-robin tie-break, caps outstanding strobes
// and aborts hung transfers with ERR via a watchdog.
//   clk_i, rst_i (async, active-low)
//   m0_* / m1_*  : master ports (cyc/stb/we/adr/dat/sel in; dat/ack/err/stall out)
//   s_*          : single master port towards the crossbar
//   grant_o      : one-hot current owner ({m1, m0}), 00 when idle
//   timeout_o    : one-cycle pulse when the watchdog aborts a transfer
module wb_arbiter2
    import calsoc_wb_pkg::*;
#(
    parameter int unsigned AW              = WB_AW,
    parameter int unsigned DW              = WB_DW,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_stall_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_stall_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_stall_i,

    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t    state_q, state_d;
    master_idx_t   last_grant_q, last_grant_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          abort_entry_q;

    logic          granted;
    master_idx_t   owner;
    logic          sel0, sel1;

    logic            g_cyc, g_stb, g_we;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [DW/8-1:0] g_sel;

    logic          full, accept, resp;
    logic          wd_enable, wd_clear, wd_expire;

    logic [DW-1:0] rsp_dat;
    logic          rsp_ack, rsp_err, rsp_stall;

    // Owner follows the state; ABORT keeps the master that was granted.
    always_comb begin
        granted = (state_q == GRANT0) || (state_q == GRANT1);
        owner   = (state_q == GRANT1) || ((state_q == ABORT) && last_grant_q);
        sel0    = (state_q != IDLE) && !owner;
        sel1    = (state_q != IDLE) &&  owner;
    end

    always_comb begin
        g_cyc = owner ? m1_cyc_i : m0_cyc_i;
        g_stb = owner ? m1_stb_i : m0_stb_i;
        g_we  = owner ? m1_we_i  : m0_we_i;
        g_adr = owner ? m1_adr_i : m0_adr_i;
        g_dat = owner ? m1_dat_i : m0_dat_i;
        g_sel = owner ? m1_sel_i : m0_sel_i;
    end

    always_comb begin
        full    = (out_cnt_q == CW'(MAX_OUTSTANDING));
        s_cyc_o = granted && g_cyc;
        s_stb_o = s_cyc_o && g_stb && !full;
        s_we_o  = granted && g_we;
        s_adr_o = granted ? g_adr : '0;
        s_dat_o = granted ? g_dat : '0;
        s_sel_o = granted ? g_sel : '0;
        accept  = s_stb_o && !s_stall_i;
        resp    = s_ack_i || s_err_i;
    end

    // Response path seen by the owner; late slave responses in ABORT are dropped.
    always_comb begin
        rsp_dat   = '0;
        rsp_ack   = 1'b0;
        rsp_err   = 1'b0;
        rsp_stall = 1'b1;
        if (granted) begin
            rsp_dat   = s_dat_i;
            rsp_ack   = s_ack_i;
            rsp_err   = s_err_i;
            rsp_stall = s_stall_i || full;
        end else if (state_q == ABORT) begin
            rsp_err   = abort_entry_q;
        end
    end

    always_comb begin
        m0_dat_o   = sel0 ? rsp_dat : '0;
        m0_ack_o   = sel0 && rsp_ack;
        m0_err_o   = sel0 && rsp_err;
        m0_stall_o = sel0 ? rsp_stall : 1'b1;
        m1_dat_o   = sel1 ? rsp_dat : '0;
        m1_ack_o   = sel1 && rsp_ack;
        m1_err_o   = sel1 && rsp_err;
        m1_stall_o = sel1 ? rsp_stall : 1'b1;
        grant_o    = {sel1, sel0};
        timeout_o  = (state_q == ABORT) && abort_entry_q;
    end

    always_comb begin
        wd_enable = granted && g_cyc && (out_cnt_q != '0);
        wd_clear  = !granted || !g_cyc || resp || (out_cnt_q == '0);
    end

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .enable (wd_enable),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_cnt_d    = out_cnt_q;
        case (state_q)
            IDLE: begin
                out_cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    last_grant_d = master_idx_t'(~last_grant_q);
                    state_d      = grant_state(master_idx_t'(~last_grant_q));
                end else if (m0_cyc_i) begin
                    last_grant_d = 1'b0;
                    state_d      = GRANT0;
                end else if (m1_cyc_i) begin
                    last_grant_d = 1'b1;
                    state_d      = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!g_cyc) begin
                    state_d   = IDLE;
                    out_cnt_d = '0;
                end else begin
                    // Saturates at 0 when a response arrives with nothing counted.
                    if (accept && !resp) begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end else if (!accept && resp && (out_cnt_q != '0)) begin
                        out_cnt_d = out_cnt_q - CW'(1);
                    end
                    if (wd_expire) begin
                        state_d   = ABORT;
                        out_cnt_d = '0;
                    end
                end
            end
            ABORT: begin
                out_cnt_d = '0;
                if (!g_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                out_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            out_cnt_q     <= '0;
            abort_entry_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            out_cnt_q     <= out_cnt_d;
            abort_entry_q <= (state_d == ABORT) && (state_q != ABORT);
        end
    end

endmodule
